reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file for the pipelined MIPS core, successor to the single-cycle core's register file. Provides NUM_RD combinational read ports, one synchronous write port, a hardware clear sequencer that zeroes every entry after reset, and a per-register busy scoreboard used by the issue stage for RAW hazard detection. It sits between decode (reads and busy lookup) and writeback (write and busy clear).

## Interface
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries.
- NUM_RD, 2, number of read ports (1..4).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- ready  output  1  high when the clear sequence is done and the file accepts writes.
- raddr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  output  NUM_RD*DATA_WIDTH  packed read data, same packing.
- rbusy  output  NUM_RD  busy bit of each read address.
- wen  input  1  write enable.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- set_en  input  1  mark set_addr busy (instruction issued with that destination).
- set_addr  input  ADDR_WIDTH  register to mark busy.

## Operation
- States: CLEAR, RUN.
- rst high: state <= CLEAR, clear counter <= 0, all busy bits <= 0, ready = 0.
- CLEAR (rst low): each cycle write 0 to entry counter, counter += 1. When counter == DEPTH-1 is written, state <= RUN on that edge. wen and set_en are ignored in CLEAR. rdata = 0 and rbusy = 0 for all ports in CLEAR.
- RUN: ready = 1. wen && waddr != 0 writes wdata to waddr on the rising edge. Writes to register 0 are dropped; rdata for address 0 is always 0.
- Scoreboard, RUN only: wen && waddr != 0 clears busy[waddr]. set_en && set_addr != 0 sets busy[set_addr]. The same address set and cleared in one cycle ends busy (set wins: a new producer has issued). busy[0] is always 0.
- Reads are combinational: rdata[i] = rf[raddr[i]] and rbusy[i] = busy[raddr[i]], subject to bypass (see Configuration).
- Any number of read ports may address the same register.

## Timing
- Reset to ready: ready rises on the DEPTH-th rising edge after rst falls (32 cycles at default). Reset values: ready = 0, rdata = 0, rbusy = 0.
- rst asserted mid-clear or in RUN: the next edge returns to CLEAR with counter 0. The full sequence restarts and register contents are not retained.
- Write latency: data is visible on reads in the cycle after the write edge without bypass, and in the same cycle with bypass.
- Busy set latency: rbusy reflects set_en on the cycle after the edge. The clear is bypassed only when bypass is enabled.
- The counter is ADDR_WIDTH bits wide. The CLEAR-to-RUN transition uses counter == DEPTH-1 and never relies on wrap-around.

## Configuration
- REG_FILE_BYPASS_EN defined: in RUN, if wen && waddr != 0 && waddr == raddr[i], then rdata[i] = wdata and rbusy[i] = 0 combinationally. If set_en targets the same address in that cycle, rbusy[i] is still 0 for the current cycle.
- Undefined: there are no combinational write-to-read or clear-to-busy paths. Reads return the stored value and the stored busy bit only.

## Test plan
- Reset clear: preload entries via writes, pulse rst for 1 cycle -> ready = 0 for exactly 32 edges, then 1. Every address then reads 0, and wen during CLEAR has no effect.
- Basic RUN access: write 0xDEADBEEF to r5 and 0x12345678 to r31 -> the next cycle raddr = {5, 31} returns both values. Writing 0xFFFFFFFF to r0 still reads 0.
- Bypass (macro defined): wen = 1, waddr = 7, wdata = 0xA5A5A5A5, raddr0 = 7 in the same cycle -> rdata0 = 0xA5A5A5A5 and rbusy0 = 0. With the macro undefined, rdata0 shows the old value that cycle.
- Scoreboard: set_en on r9 -> rbusy = 1 the next cycle. A later wen to r9 -> rbusy = 0. set_en and wen both on r9 in one cycle -> r9 is busy afterwards. set_en on r0 -> never busy.
- Mid-clear reset: assert rst at clear cycle 10 -> the counter restarts and ready rises 32 edges after the second rst falls.
- Multi-port: NUM_RD = 3, all ports read r12 = 0x00000042 -> all three rdata = 0x42 and all rbusy equal.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with a hardware clear sequencer
// and a per-register busy scoreboard for RAW hazard detection.
//
// After reset the file walks every entry writing zero (CLEAR), then accepts
// reads, writes and scoreboard updates (RUN). Register 0 always reads zero
// and is never busy.
//
// Optional feature: define REG_FILE_BYPASS_EN to forward the in-flight
// write data (and its busy clear) straight to matching read ports.

module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         ready_o,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RD-1:0]            rbusy_o,
    input  logic                         wen_i,
    input  logic [ADDR_WIDTH-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic                         set_en_i,
    input  logic [ADDR_WIDTH-1:0]        set_addr_i
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Last entry written by the clear sequencer; the transition to RUN keys
    // on this value rather than on the counter wrapping back to zero.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rf_q [DEPTH];
    logic [DEPTH-1:0]        busy_q, busy_d;

    logic                    run;
    logic                    wr_fire;
    logic                    set_fire;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    assign run      = (state_q == RUN);
    assign ready_o  = run;
    // Architectural write / busy-set events; both are ignored outside RUN
    // and register 0 is never a target.
    assign wr_fire  = run && wen_i && (waddr_i != '0);
    assign set_fire = run && set_en_i && (set_addr_i != '0);

    // State register and clear counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register
        // samples its inputs from before the edge, independent of block order.
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: walk the counter over every entry, then enter RUN.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage write port mux: the clear sequencer owns the port in CLEAR,
    // the writeback stage owns it in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr_i;
        mem_wdata = wdata_i;
        if (!rst) begin
            if (!run) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
            end else if (wr_fire) begin
                mem_we    = 1'b1;
            end
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset term; zeroing is done one entry per
        // cycle by the clear sequencer, which keeps this a plain RAM.
        if (mem_we) begin
            rf_q[mem_waddr] <= mem_wdata;
        end
    end

    // Scoreboard next state: writeback clears, issue sets, set wins a tie.
    always_comb begin
        busy_d = busy_q;
        if (wr_fire) begin
            busy_d[waddr_i] = 1'b0;
        end
        if (set_fire) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register; reset clears every busy bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Combinational read ports.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        assign ra = raddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];

        // Read data and busy for this port; zero in CLEAR and for register 0.
        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (run && (ra != '0)) begin
                rd = rf_q[ra];
                rb = busy_q[ra];
`ifdef REG_FILE_BYPASS_EN
                // Forward the write landing this edge; the producer has
                // completed, so the register is not busy this cycle.
                if (wr_fire && (waddr_i == ra)) begin
                    rd = wdata_i;
                    rb = 1'b0;
                end
`endif
            end
        end

        assign rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign rbusy_o[i]                          = rb;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed, table-driven bench for reg_file_sb with three
// read ports. Expected values follow REG_FILE_BYPASS_EN when defined.

module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               ready;
    logic [NR*AW-1:0]   raddr;
    logic [NR*DW-1:0]   rdata;
    logic [NR-1:0]      rbusy;
    logic               wen;
    logic [AW-1:0]      waddr;
    logic [DW-1:0]      wdata;
    logic               set_en;
    logic [AW-1:0]      set_addr;

    int n_vec = 0;
    int n_err = 0;

    reg_file_sb #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_RD    (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready_o   (ready),
        .raddr_i   (raddr),
        .rdata_o   (rdata),
        .rbusy_o   (rbusy),
        .wen_i     (wen),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .set_en_i  (set_en),
        .set_addr_i(set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          set_en;
        logic [AW-1:0] set_addr;
        logic [NR*AW-1:0] raddr;
        logic [NR*DW-1:0] exp_rdata;
        logic [NR-1:0]    exp_rbusy;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [AW-1:0] wa,
                                input logic [DW-1:0] wd, input logic se,
                                input logic [AW-1:0] sa,
                                input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                input logic [AW-1:0] r2,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [DW-1:0] d2, input logic [NR-1:0] b);
        vec_t v;
        v.wen       = we;
        v.waddr     = wa;
        v.wdata     = wd;
        v.set_en    = se;
        v.set_addr  = sa;
        v.raddr     = {r2, r1, r0};
        v.exp_rdata = {d2, d1, d0};
        v.exp_rbusy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until ready rises, bounded so a stuck DUT still finishes.
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Every address must read zero and not busy on all ports.
    task automatic scan_zero(input string tag);
        for (int a = 0; a < (1 << AW); a++) begin
            raddr = {3{AW'(a)}};
            #1;
            check($sformatf("%s r%0d", tag, a), {rdata, rbusy}, '0);
        end
    endtask

    vec_t vecs[$];
    int   n_edges;

    initial begin
        rst      = 1'b1;
        wen      = 1'b0;
        waddr    = '0;
        wdata    = '0;
        set_en   = 1'b0;
        set_addr = '0;
        raddr    = {5'd3, 5'd2, 5'd1};

        // Reset state.
        repeat (2) tick();
        check("reset ready", ready, 0);
        check("reset rdata", rdata, 0);
        check("reset rbusy", rbusy, 0);

        // Clear sequence with write and busy-set traffic that must be ignored.
        wen      = 1'b1;
        waddr    = 5'd3;
        wdata    = 32'hDEAD_0003;
        set_en   = 1'b1;
        set_addr = 5'd4;
        check("clear rdata", rdata, 0);
        rst = 1'b0;
        wait_ready(n_edges);
        wen    = 1'b0;
        set_en = 1'b0;
        check("clear latency", n_edges, 32);
        scan_zero("post-clear");

        // RUN-mode vectors: inputs apply for one cycle, outputs checked
        // before the edge that commits them.
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 31, 0,
                          BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 31, 32'h12345678, 0, 0, 5, 31, 0,
                          32'hDEADBEEF, BYP ? 32'h12345678 : 32'h0, 0, 3'b000));
        vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0, 5, 31, 0,
                          32'hDEADBEEF, 32'h12345678, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 31,
                          0, 32'hDEADBEEF, 32'h12345678, 3'b000));
        vecs.push_back(mk(1, 7, 32'hA5A5A5A5, 0, 0, 7, 7, 5,
                          BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0,
                          32'hDEADBEEF, 3'b000));
        vecs.push_back(mk(0, 0, 0, 1, 9, 9, 7, 0, 0, 32'hA5A5A5A5, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 9, 9, 9, 0, 0, 0, 3'b111));
        vecs.push_back(mk(1, 9, 32'h11111111, 0, 0, 9, 9, 9,
                          BYP ? 32'h11111111 : 32'h0, BYP ? 32'h11111111 : 32'h0,
                          BYP ? 32'h11111111 : 32'h0, BYP ? 3'b000 : 3'b111));
        vecs.push_back(mk(0, 0, 0, 0, 0, 9, 0, 9,
                          32'h11111111, 0, 32'h11111111, 3'b000));
        vecs.push_back(mk(1, 9, 32'h22222222, 1, 9, 9, 9, 9,
                          BYP ? 32'h22222222 : 32'h11111111,
                          BYP ? 32'h22222222 : 32'h11111111,
                          BYP ? 32'h22222222 : 32'h11111111, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 9, 9, 9,
                          32'h22222222, 32'h22222222, 32'h22222222, 3'b111));
        vecs.push_back(mk(1, 9, 32'h33333333, 1, 9, 9, 9, 9,
                          BYP ? 32'h33333333 : 32'h22222222,
                          BYP ? 32'h33333333 : 32'h22222222,
                          BYP ? 32'h33333333 : 32'h22222222,
                          BYP ? 3'b000 : 3'b111));
        vecs.push_back(mk(0, 0, 0, 0, 0, 9, 9, 9,
                          32'h33333333, 32'h33333333, 32'h33333333, 3'b111));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        vecs.push_back(mk(1, 12, 32'h00000042, 0, 0, 12, 12, 12,
                          BYP ? 32'h42 : 32'h0, BYP ? 32'h42 : 32'h0,
                          BYP ? 32'h42 : 32'h0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12, 12, 12,
                          32'h42, 32'h42, 32'h42, 3'b000));
        vecs.push_back(mk(1, 3, 32'h00000005, 1, 12, 12, 12, 3,
                          32'h42, 32'h42, BYP ? 32'h5 : 32'h0, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12, 12, 3,
                          32'h42, 32'h42, 32'h5, 3'b011));

        foreach (vecs[k]) begin
            wen      = vecs[k].wen;
            waddr    = vecs[k].waddr;
            wdata    = vecs[k].wdata;
            set_en   = vecs[k].set_en;
            set_addr = vecs[k].set_addr;
            raddr    = vecs[k].raddr;
            #1;
            check($sformatf("vec%0d rdata", k), rdata, vecs[k].exp_rdata);
            check($sformatf("vec%0d rbusy", k), rbusy, vecs[k].exp_rbusy);
            check($sformatf("vec%0d ready", k), ready, 1);
            tick();
        end
        wen    = 1'b0;
        set_en = 1'b0;

        // Reset from RUN with live contents, then a second reset mid-clear.
        raddr = {5'd12, 5'd31, 5'd5};
        rst   = 1'b1;
        tick();
        check("run-reset ready", ready, 0);
        check("run-reset rdata", rdata, 0);
        check("run-reset rbusy", rbusy, 0);
        rst = 1'b0;
        repeat (10) tick();
        check("mid-clear ready", ready, 0);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        wen      = 1'b1;
        waddr    = 5'd2;
        wdata    = 32'hBAD0_0002;
        set_en   = 1'b1;
        set_addr = 5'd12;
        wait_ready(n_edges);
        wen    = 1'b0;
        set_en = 1'b0;
        check("restart latency", n_edges, 32);
        scan_zero("post-restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
